// File: rtl/event_encoder16_if.sv
// rtl/event_encoder16_if.sv - code output stream between the encoder and its consumer
interface event_encoder16_if;
    logic [3:0] X;
    logic       VALID;
    logic       READY;

    modport master (output X, output VALID, input READY);
    modport slave  (input X, input VALID, output READY);
endinterface

// File: rtl/event_encoder16.sv
// rtl/event_encoder16.sv - captures event lines into a pending bitmap and drains them as 4-bit codes
module event_encoder16 (
    input  logic                      CLK,
    input  logic                      RESET_L,
    input  logic                      E1,
    input  logic                      E0_L,
    input  logic [15:0]               Y,
    event_encoder16_if.master         code_bus,
    output logic [15:0]               PEND,
    output logic                      OVF
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  x_r, x_nxt;
    logic [15:0] pend_r, pend_nxt;
    logic        ovf_r, ovf_nxt;

    logic        en;
    logic [15:0] set_bits;
    logic [15:0] cand;
    logic        free;
    logic [3:0]  high_idx;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state  <= EMPTY;
            x_r    <= 4'h0;
            pend_r <= 16'h0000;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            x_r    <= x_nxt;
            pend_r <= pend_nxt;
            ovf_r  <= ovf_nxt;
        end
    end

    always_comb begin
        en        = E1 & ~E0_L;
        set_bits  = en ? Y : 16'h0000;
        cand      = pend_r | set_bits;
        free      = (state == EMPTY) | code_bus.READY;

        // Ascending scan: the last set bit seen is the highest-priority one.
        high_idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (cand[i]) begin
                high_idx = i[3:0];
            end
        end

        state_nxt = state;
        x_nxt     = x_r;
        pend_nxt  = cand;
        // A line re-asserted while still pending merges into one event.
        ovf_nxt   = ovf_r | (|(set_bits & pend_r));

        if (free) begin
            if (|cand) begin
                state_nxt = HOLD;
                x_nxt     = high_idx;
                pend_nxt  = cand & ~(16'h0001 << high_idx);
            end else begin
                state_nxt = EMPTY;
                pend_nxt  = 16'h0000;
            end
        end
    end

    assign code_bus.X     = x_r;
    assign code_bus.VALID = (state == HOLD);
    assign PEND           = pend_r;
    assign OVF            = ovf_r;

endmodule

// File: tb/tb_event_encoder16.sv
// tb/tb_event_encoder16.sv - scoreboard bench for event_encoder16
module tb_event_encoder16;

    logic        CLK;
    logic        RESET_L;
    logic        E1;
    logic        E0_L;
    logic [15:0] Y;
    logic [15:0] PEND;
    logic        OVF;

    event_encoder16_if bus ();

    event_encoder16 dut (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .E1       (E1),
        .E0_L     (E0_L),
        .Y        (Y),
        .code_bus (bus),
        .PEND     (PEND),
        .OVF      (OVF)
    );

    typedef struct {
        logic [3:0]  x;
        logic [15:0] pend;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   done   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] x, input logic [15:0] pend, input logic ovf);
        exp_t e;
        e.x    = x;
        e.pend = pend;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Every cycle the DUT presents a code, it must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (!done && bus.VALID === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_code: got X=%0h PEND=%0h expected no code", bus.X, PEND);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_x", {28'h0, bus.X}, {28'h0, e.x});
                chk("mon_pend", {16'h0, PEND}, {16'h0, e.pend});
                chk("mon_ovf", {31'h0, OVF}, {31'h0, e.ovf});
            end
        end
    end

    initial begin
        RESET_L   = 1'b0;
        E1        = 1'b1;
        E0_L      = 1'b0;
        Y         = 16'h0000;
        bus.READY = 1'b1;
        #3;
        chk("rst_x", {28'h0, bus.X}, 32'h0);
        chk("rst_valid", {31'h0, bus.VALID}, 32'h0);
        chk("rst_pend", {16'h0, PEND}, 32'h0);
        chk("rst_ovf", {31'h0, OVF}, 32'h0);
        step();
        step();
        RESET_L = 1'b1;
        step();

        // Single event
        push(4'd0, 16'h0000, 1'b0);
        Y = 16'h0001;
        step();
        Y = 16'h0000;
        step();
        chk("single_drained", {31'h0, bus.VALID}, 32'h0);

        // Burst drain
        push(4'd7, 16'h0070, 1'b0);
        push(4'd6, 16'h0030, 1'b0);
        push(4'd5, 16'h0010, 1'b0);
        push(4'd4, 16'h0000, 1'b0);
        Y = 16'h00F0;
        step();
        Y = 16'h0000;
        repeat (4) step();
        chk("burst_drained", {31'h0, bus.VALID}, 32'h0);
        chk("burst_ovf", {31'h0, OVF}, 32'h0);

        // Backpressure: 15 held for 5 presented cycles, then 0
        repeat (5) push(4'd15, 16'h0001, 1'b0);
        push(4'd0, 16'h0000, 1'b0);
        bus.READY = 1'b0;
        Y = 16'h8001;
        step();
        Y = 16'h0000;
        repeat (4) step();
        bus.READY = 1'b1;
        step();
        step();
        chk("bp_drained", {31'h0, bus.VALID}, 32'h0);

        // Overflow and preemption on the accept edge
        push(4'd1, 16'h0001, 1'b0);
        push(4'd1, 16'h0001, 1'b1);
        push(4'd8, 16'h0001, 1'b1);
        push(4'd0, 16'h0000, 1'b1);
        bus.READY = 1'b0;
        Y = 16'h0003;
        step();
        Y = 16'h0001;
        step();
        Y = 16'h0100;
        bus.READY = 1'b1;
        step();
        Y = 16'h0000;
        step();
        step();
        chk("ovf_drained", {31'h0, bus.VALID}, 32'h0);
        chk("ovf_sticky", {31'h0, OVF}, 32'h1);

        // Enable gating
        E0_L = 1'b1;
        Y = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_valid", {31'h0, bus.VALID}, 32'h0);
            chk("gate_pend", {16'h0, PEND}, 32'h0);
        end
        E1 = 1'b0;
        step();
        chk("gate_e1_pend", {16'h0, PEND}, 32'h0);
        Y = 16'h0000;
        E1 = 1'b1;
        E0_L = 1'b0;

        // Drain continues with E1 dropped mid-drain
        push(4'd2, 16'h0003, 1'b1);
        push(4'd1, 16'h0001, 1'b1);
        push(4'd0, 16'h0000, 1'b1);
        Y = 16'h0007;
        step();
        Y = 16'h0000;
        E1 = 1'b0;
        step();
        step();
        step();
        chk("gate_drained", {31'h0, bus.VALID}, 32'h0);
        E1 = 1'b1;

        // Reset mid-operation
        bus.READY = 1'b0;
        Y = 16'h1F00;
        step();
        Y = 16'h0000;
        chk("pre_rst_valid", {31'h0, bus.VALID}, 32'h1);
        chk("pre_rst_pend", {16'h0, PEND}, 32'h0F00);
        #1;
        RESET_L = 1'b0;
        #1;
        chk("mid_rst_x", {28'h0, bus.X}, 32'h0);
        chk("mid_rst_valid", {31'h0, bus.VALID}, 32'h0);
        chk("mid_rst_pend", {16'h0, PEND}, 32'h0);
        chk("mid_rst_ovf", {31'h0, OVF}, 32'h0);
        bus.READY = 1'b1;
        step();
        step();
        RESET_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", {31'h0, bus.VALID}, 32'h0);
        end

        @(negedge CLK);
        #1;
        done = 1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
